// File: rtl/instruction_pkg.sv
// Shared opcode/funct constants, field positions and the decoded bundle type
// for the MIPS-format instruction decoder.
package instruction_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_LSB   = 0;

  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      func;
    logic [15:0]     imm16;
    logic [25:0]     target;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_zext;
    logic            is_rtype;
    logic            is_jump;
    logic            is_branch;
    logic            is_load;
    logic            is_store;
    logic            is_itype;
    logic            illegal;
  } decoded_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/instruction_classify.sv
// Combinational op/func to instruction-class decoder.
// Optional illegal-encoding detection when INSTR_DECODE_ILLEGAL_EN is defined.
module instruction_classify
  import instruction_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       is_rtype,
  output logic       is_jump,
  output logic       is_branch,
  output logic       is_load,
  output logic       is_store,
  output logic       is_itype,
  output logic       illegal
);

  logic rtype_raw, jump_raw, branch_raw, load_raw, store_raw;

  always_comb begin
    rtype_raw  = (op == OP_RTYPE);
    jump_raw   = (op == OP_J)   || (op == OP_JAL);
    branch_raw = (op == OP_BEQ) || (op == OP_BNE);
    load_raw   = (op == OP_LW);
    store_raw  = (op == OP_SW);
  end

`ifdef INSTR_DECODE_ILLEGAL_EN
  logic op_known, func_known;

  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
    func_known = 1'b0;
    case (func)
      FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: func_known = 1'b1;
      default: func_known = 1'b0;
    endcase
  end

  // An illegal encoding suppresses every class flag, is_itype included.
  always_comb begin
    illegal   = !op_known || (rtype_raw && !func_known);
    is_rtype  = rtype_raw  && !illegal;
    is_jump   = jump_raw   && !illegal;
    is_branch = branch_raw && !illegal;
    is_load   = load_raw   && !illegal;
    is_store  = store_raw  && !illegal;
    is_itype  = !illegal && !(rtype_raw || jump_raw || branch_raw || load_raw || store_raw);
  end
`else
  logic unused_func;

  always_comb begin
    unused_func = ^func;
    illegal   = 1'b0;
    is_rtype  = rtype_raw;
    is_jump   = jump_raw;
    is_branch = branch_raw;
    is_load   = load_raw;
    is_store  = store_raw;
    is_itype  = !(rtype_raw || jump_raw || branch_raw || load_raw || store_raw);
  end
`endif

endmodule

// File: rtl/instruction_decode.sv
// Registered MIPS instruction field extractor/decoder, one-cycle latency.
// Define INSTR_DECODE_ILLEGAL_EN to add the registered illegal output.
module instruction_decode
  import instruction_pkg::*;
#(
  parameter int XLEN = instruction_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  output logic            out_valid,
  output logic [5:0]      op,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      func,
  output logic [15:0]     imm16,
  output logic [25:0]     target,
  output logic [XLEN-1:0] imm_sext,
  output logic [XLEN-1:0] imm_zext,
  output logic            is_rtype,
  output logic            is_jump,
  output logic            is_branch,
  output logic            is_load,
  output logic            is_store,
`ifdef INSTR_DECODE_ILLEGAL_EN
  output logic            illegal,
`endif
  output logic            is_itype
);

  decoded_t d, q;
  logic     valid_q;
  logic     c_rtype, c_jump, c_branch, c_load, c_store, c_itype, c_illegal;

  instruction_classify u_classify (
    .op        (instr[OP_LSB +: 6]),
    .func      (instr[FUNC_LSB +: 6]),
    .is_rtype  (c_rtype),
    .is_jump   (c_jump),
    .is_branch (c_branch),
    .is_load   (c_load),
    .is_store  (c_store),
    .is_itype  (c_itype),
    .illegal   (c_illegal)
  );

  // Slicing is positional only; every field is produced regardless of format.
  always_comb begin
    d           = '0;
    d.op        = instr[OP_LSB +: 6];
    d.rs        = instr[RS_LSB +: 5];
    d.rt        = instr[RT_LSB +: 5];
    d.rd        = instr[RD_LSB +: 5];
    d.shamt     = instr[SHAMT_LSB +: 5];
    d.func      = instr[FUNC_LSB +: 6];
    d.imm16     = instr[15:0];
    d.target    = instr[25:0];
    d.imm_sext  = sext16(instr[15:0]);
    d.imm_zext  = {{(instruction_pkg::XLEN-16){1'b0}}, instr[15:0]};
    d.is_rtype  = c_rtype;
    d.is_jump   = c_jump;
    d.is_branch = c_branch;
    d.is_load   = c_load;
    d.is_store  = c_store;
    d.is_itype  = c_itype;
    d.illegal   = c_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) q <= d;
    end
  end

  always_comb begin
    out_valid = valid_q;
    op        = q.op;
    rs        = q.rs;
    rt        = q.rt;
    rd        = q.rd;
    shamt     = q.shamt;
    func      = q.func;
    imm16     = q.imm16;
    target    = q.target;
    imm_sext  = q.imm_sext;
    imm_zext  = q.imm_zext;
    is_rtype  = q.is_rtype;
    is_jump   = q.is_jump;
    is_branch = q.is_branch;
    is_load   = q.is_load;
    is_store  = q.is_store;
    is_itype  = q.is_itype;
  end

`ifdef INSTR_DECODE_ILLEGAL_EN
  assign illegal = q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = q.illegal;
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// Randomized + directed bench for instruction_decode against an arithmetic reference model.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'h0;

  logic        out_valid;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] imm_sext, imm_zext;
  logic        is_rtype, is_jump, is_branch, is_load, is_store, is_itype;
  logic        illegal_o;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  instruction_decode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .instr     (instr),
    .out_valid (out_valid),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .func      (func),
    .imm16     (imm16),
    .target    (target),
    .imm_sext  (imm_sext),
    .imm_zext  (imm_zext),
    .is_rtype  (is_rtype),
    .is_jump   (is_jump),
    .is_branch (is_branch),
    .is_load   (is_load),
    .is_store  (is_store),
`ifdef INSTR_DECODE_ILLEGAL_EN
    .illegal   (illegal_o),
`endif
    .is_itype  (is_itype)
  );

`ifndef INSTR_DECODE_ILLEGAL_EN
  assign illegal_o = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model: expected outputs as plain integers; index 16 = illegal.
  bit [31:0] m_word  = 32'h0;
  bit        m_valid = 1'b0;
  bit        m_any   = 1'b0;

  function automatic bit is_illegal_word(input bit [31:0] w);
`ifdef INSTR_DECODE_ILLEGAL_EN
    int o, f;
    o = int'(w >> 26);
    f = int'(w % 64);
    if (!(o inside {0, 2, 3, 4, 5, 8, 9, 12, 13, 15, 35, 43})) return 1'b1;
    if (o == 0 && !(f inside {0, 2, 3, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43})) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Returns expected value of output slot k, given the last accepted word.
  function automatic bit [31:0] expect_out(input int k, input bit [31:0] w, input bit any);
    int o;
    bit ill;
    bit [31:0] lo;
    if (!any) return 32'h0;
    o   = int'(w >> 26);
    lo  = w % 65536;
    ill = is_illegal_word(w);
    case (k)
      0:  return 32'(o);
      1:  return (w >> 21) % 32;
      2:  return (w >> 16) % 32;
      3:  return (w >> 11) % 32;
      4:  return (w >> 6) % 32;
      5:  return w % 64;
      6:  return lo;
      7:  return w % (1 << 26);
      8:  return (lo >= 32768) ? (lo + 32'hFFFF0000) : lo;
      9:  return lo;
      10: return 32'(!ill && o == 0);
      11: return 32'(!ill && (o == 2 || o == 3));
      12: return 32'(!ill && (o == 4 || o == 5));
      13: return 32'(!ill && o == 35);
      14: return 32'(!ill && o == 43);
      15: return 32'(!ill && !(o inside {0, 2, 3, 4, 5, 35, 43}));
      16: return 32'(ill);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [31:0] actual_out(input int k);
    case (k)
      0:  return 32'(op);
      1:  return 32'(rs);
      2:  return 32'(rt);
      3:  return 32'(rd);
      4:  return 32'(shamt);
      5:  return 32'(func);
      6:  return 32'(imm16);
      7:  return 32'(target);
      8:  return imm_sext;
      9:  return imm_zext;
      10: return 32'(is_rtype);
      11: return 32'(is_jump);
      12: return 32'(is_branch);
      13: return 32'(is_load);
      14: return 32'(is_store);
      15: return 32'(is_itype);
      16: return 32'(illegal_o);
      default: return 32'h0;
    endcase
  endfunction

  string names [17] = '{"op", "rs", "rt", "rd", "shamt", "func", "imm16", "target",
                        "imm_sext", "imm_zext", "is_rtype", "is_jump", "is_branch",
                        "is_load", "is_store", "is_itype", "illegal"};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_any   = 1'b0;
      m_word  = 32'h0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_word = instr;
        m_any  = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input bit [31:0] act, input bit [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, mid-low phase.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      for (int k = 0; k < 17; k++)
        chk(names[k], actual_out(k), expect_out(k, m_word, m_any));
    end
  end

  task automatic send(input bit [31:0] w, input bit v);
    @(negedge clk);
    #1;
    instr    = w;
    in_valid = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset held with junk on the inputs.
    for (int i = 0; i < 3; i++) send($urandom, 1'b1);
    after_edge();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_target", 32'(target), 32'h0);
    chk("rst_imm_sext", imm_sext, 32'h0);
    chk("rst_is_itype", 32'(is_itype), 32'h0);

    @(negedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    after_edge(); after_edge();
    chk("rel_out_valid", 32'(out_valid), 32'h0);
    chk("rel_op", 32'(op), 32'h0);

    // R-type then store back-to-back, then idle.
    send(32'h02538820, 1'b1);
    after_edge();
    chk("r_valid", 32'(out_valid), 32'h1);
    chk("r_rs", 32'(rs), 32'd18);
    chk("r_rt", 32'(rt), 32'd19);
    chk("r_rd", 32'(rd), 32'd17);
    chk("r_func", 32'(func), 32'h20);
    chk("r_target", 32'(target), 32'h2538820);
    chk("r_imm_sext", imm_sext, 32'hFFFF8820);
    chk("r_imm_zext", imm_zext, 32'h00008820);
    chk("r_is_rtype", 32'(is_rtype), 32'h1);
    send(32'hAE320000, 1'b1);
    after_edge();
    chk("s_valid", 32'(out_valid), 32'h1);
    chk("s_op", 32'(op), 32'h2B);
    chk("s_rs", 32'(rs), 32'd17);
    chk("s_rt", 32'(rt), 32'd18);
    chk("s_target", 32'(target), 32'h2320000);
    chk("s_is_store", 32'(is_store), 32'h1);
    chk("s_is_itype", 32'(is_itype), 32'h0);
    send(32'h12345678, 1'b0);
    after_edge();
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_op_hold", 32'(op), 32'h2B);
    chk("idle_store_hold", 32'(is_store), 32'h1);

    send(32'h08000010, 1'b1);
    after_edge();
    chk("j_is_jump", 32'(is_jump), 32'h1);
    chk("j_target", 32'(target), 32'h10);
    send(32'h1109FFFC, 1'b1);
    after_edge();
    chk("b_is_branch", 32'(is_branch), 32'h1);
    chk("b_imm_sext", imm_sext, 32'hFFFFFFFC);
    send(32'h8D2A0004, 1'b1);
    after_edge();
    chk("lw_is_load", 32'(is_load), 32'h1);
    chk("lw_imm_zext", imm_zext, 32'h4);

    // Async reset between edges clears outputs immediately.
    send(32'h3C01ABCD, 1'b1);
    @(posedge clk);
    #2;
    chk("pre_arst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_imm_zext", imm_zext, 32'h0);
    chk("arst_is_itype", 32'(is_itype), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;

`ifdef INSTR_DECODE_ILLEGAL_EN
    send(32'hFC000000, 1'b1);
    after_edge();
    chk("ill_flag", 32'(illegal_o), 32'h1);
    chk("ill_itype", 32'(is_itype), 32'h0);
    send(32'h00000001, 1'b1);
    after_edge();
    chk("ill_func", 32'(illegal_o), 32'h1);
    chk("ill_func_rtype", 32'(is_rtype), 32'h0);
`endif

    // Random traffic: mix of known opcodes and fully random words.
    for (int i = 0; i < 400; i++) begin
      bit [31:0] w;
      bit [5:0]  ops [12];
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 11)];
      if (w[31:26] == 6'h00 && $urandom_range(0, 1) == 1) w[5:0] = 6'h20 + 6'($urandom_range(0, 7));
      send(w, 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 60) == 0) begin
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end
    send(32'h0, 1'b0);
    after_edge();
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Registered field extractor and decoder for 32-bit MIPS-format instruction words; sits between the instruction-fetch register and the control unit / register file.
- Splits the word into op, Rs, Rt, Rd, shamt, func, imm16 and 26-bit jump target.
- Also produces sign- and zero-extended immediates and instruction-class flags.
- One clock, one-cycle latency, valid-qualified.

Parameters:
- XLEN, 32, width of extended immediate outputs; legal values 32 only, retained for package consistency.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr is valid this cycle
- instr  in  32  instruction word
- out_valid  out  1  registered copy of in_valid
- op  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- func  out  6  instr[5:0]
- imm16  out  16  instr[15:0]
- target  out  26  instr[25:0]
- imm_sext  out  XLEN  imm16 sign-extended
- imm_zext  out  XLEN  imm16 zero-extended
- is_rtype  out  1  op==6'h00
- is_jump  out  1  op==6'h02 (j) or 6'h03 (jal)
- is_branch  out  1  op==6'h04 (beq) or 6'h05 (bne)
- is_load  out  1  op==6'h23 (lw)
- is_store  out  1  op==6'h2B (sw)
- is_itype  out  1  none of the other class flags set

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0, including out_valid.
- Reset release is synchronous to the next clk edge.
- Each rising clk edge with in_valid=1 registers all fields and flags decoded from instr; out_valid=1 in the following cycle (latency 1).
- Each rising clk edge with in_valid=0: out_valid goes to 0; all field and flag outputs hold their previous values.
- Field slicing is purely positional and independent of op.
  - rd, shamt and func are produced for I/J formats too.
  - imm16 and target are produced for R format too.
- imm_sext = {16{instr[15]}, instr[15:0]}; imm_zext = {16'h0, instr[15:0]}.
- Class flags are mutually exclusive; exactly one is 1 after any accepted instruction.
- No handshake back-pressure; a new instruction is accepted every cycle.
- A reset asserted mid-stream discards the in-flight word.

Optional Feature:
- Macro INSTR_DECODE_ILLEGAL_EN.
- When defined:
  - Adds output illegal (1 bit, registered with the other outputs, reset 0).
  - illegal=1 when op is not in {00,02,03,04,05,08,09,0C,0D,0F,23,2B}, or when op==00 and func is not in {00,02,03,08,20,21,22,23,24,25,26,27,2A,2B}.
  - When illegal=1, all class flags are 0, including is_itype.
- When undefined: port absent; class decode as above.

Decomposition:
- Package instruction_pkg holds:
  - opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, …)
  - funct localparams
  - field bit-position constants
  - a packed struct typedef for the decoded bundle.
- Natural sub-module: instruction_classify, a combinational op/func to class-flag (and illegal) decoder, instantiated once ahead of the output register.

Test Plan:
- Reset: hold rst_n=0 with arbitrary instr -> all outputs 0, out_valid=0; release without in_valid -> outputs stay 0.
- R-type: in_valid=1, instr=32'h02538820 -> next cycle: op=0, rs=18, rt=19, rd=17, shamt=0, func=6'h20, imm16=16'h8820, target=26'h2538820, imm_sext=32'hFFFF8820, imm_zext=32'h00008820, is_rtype=1.
- Store: instr=32'hAE320000 -> op=6'h2B, rs=17, rt=18, rd=0, func=0, imm16=0, target=26'h2320000, is_store=1, all other flags 0.
- Back-to-back: the two words above on consecutive cycles -> out_valid high two cycles, fields update every cycle; in_valid=0 afterwards -> out_valid=0 and fields hold the store decode.
- Jump / branch / load: 32'h08000010 -> is_jump=1, target=26'h10; 32'h1109FFFC -> is_branch=1, imm_sext=32'hFFFFFFFC; 32'h8D2A0004 -> is_load=1.
- Async reset mid-stream: assert rst_n=0 between clk edges -> outputs clear immediately, without waiting for a clk edge. With INSTR_DECODE_ILLEGAL_EN defined: 32'hFC000000 -> illegal=1, all class flags 0.
